// File: rtl/uart_tx_arbiter_if.sv
// Requester/transmitter-side bundle of the shared UART TX arbiter.
// master = arbiter side, slave = requesters plus transmitter side.
interface uart_tx_arbiter_if #(
    parameter int unsigned N_BITS_DATA  = 8,
    parameter int unsigned N_REQ        = 4,
    parameter int unsigned N_GRANT_BITS = 2
);
    logic [N_REQ-1:0]             req_valid;
    logic [N_REQ*N_BITS_DATA-1:0] req_data;
    logic [N_REQ-1:0]             req_ack;
    logic                         tx_start;
    logic [N_BITS_DATA-1:0]       tx_data;
    logic [N_GRANT_BITS-1:0]      grant_id;
    logic                         busy;

    modport master (
        input  req_valid, req_data,
        output req_ack, tx_start, tx_data, grant_id, busy
    );

    modport slave (
        output req_valid, req_data,
        input  req_ack, tx_start, tx_data, grant_id, busy
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter between N_REQ byte producers.
// It grants one byte, pulses tx_start, then waits out the frame plus a guard interval in baud ticks.
module uart_tx_arbiter #(
    parameter int unsigned N_BITS_DATA  = 8,
    parameter int unsigned N_REQ        = 4,
    parameter int unsigned N_GRANT_BITS = 2,
    parameter int unsigned N_CNT_BITS   = 9,
    parameter int unsigned FRAME_TICKS  = 176,
    parameter int unsigned GUARD_TICKS  = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 s_ticks,
    uart_tx_arbiter_if.master    bus
);
    localparam int unsigned            GUARD_LAST_I = (GUARD_TICKS == 0) ? 0 : GUARD_TICKS - 1;
    localparam logic [N_CNT_BITS-1:0]  FRAME_LAST   = N_CNT_BITS'(FRAME_TICKS - 1);
    localparam logic [N_CNT_BITS-1:0]  GUARD_LAST   = N_CNT_BITS'(GUARD_LAST_I);
    localparam logic [N_GRANT_BITS-1:0] LAST_INIT   = N_GRANT_BITS'(N_REQ - 1);
    localparam logic [N_REQ-1:0]       ACK_ONE      = N_REQ'(1);

    typedef enum logic [3:0] {
        IDLE  = 4'b0001,
        LOAD  = 4'b0010,
        FRAME = 4'b0100,
        GUARD = 4'b1000
    } state_t;

    state_t                  state;
    logic [N_CNT_BITS-1:0]   cnt;
    logic [N_GRANT_BITS-1:0] last;

    logic                    win_valid_c;
    logic [N_GRANT_BITS-1:0] win_id_c;
    logic [N_GRANT_BITS-1:0] idx_c;
    logic [N_BITS_DATA-1:0]  req_bytes [N_REQ];

    for (genvar g = 0; g < int'(N_REQ); g++) begin : g_unpack
        assign req_bytes[g] = bus.req_data[g*N_BITS_DATA +: N_BITS_DATA];
    end

    // Scan from farthest to nearest after the pointer so the nearest valid requester wins.
    always_comb begin
        win_valid_c = 1'b0;
        win_id_c    = '0;
        idx_c       = '0;
        for (int k = int'(N_REQ); k >= 1; k--) begin
            idx_c = N_GRANT_BITS'((int'(last) + k) % int'(N_REQ));
            if (bus.req_valid[idx_c]) begin
                win_valid_c = 1'b1;
                win_id_c    = idx_c;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            cnt          <= '0;
            last         <= LAST_INIT;
            bus.req_ack  <= '0;
            bus.tx_start <= 1'b0;
            bus.tx_data  <= '0;
            bus.grant_id <= '0;
            bus.busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_valid_c) begin
                        bus.tx_data  <= req_bytes[win_id_c];
                        bus.grant_id <= win_id_c;
                        last         <= win_id_c;
                        bus.req_ack  <= ACK_ONE << win_id_c;
                        bus.tx_start <= 1'b1;
                        bus.busy     <= 1'b1;
                        state        <= LOAD;
                    end
                end
                LOAD: begin
                    bus.req_ack  <= '0;
                    bus.tx_start <= 1'b0;
                    cnt          <= '0;
                    state        <= FRAME;
                end
                FRAME: begin
                    if (s_ticks) begin
                        if (cnt == FRAME_LAST) begin
                            cnt <= '0;
                            if (GUARD_TICKS == 0) begin
                                bus.busy <= 1'b0;
                                state    <= IDLE;
                            end else begin
                                state    <= GUARD;
                            end
                        end else begin
                            cnt <= cnt + N_CNT_BITS'(1);
                        end
                    end
                end
                GUARD: begin
                    if (s_ticks) begin
                        if (cnt == GUARD_LAST) begin
                            cnt      <= '0;
                            bus.busy <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            cnt <= cnt + N_CNT_BITS'(1);
                        end
                    end
                end
                default: begin
                    cnt          <= '0;
                    bus.req_ack  <= '0;
                    bus.tx_start <= 1'b0;
                    bus.busy     <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus a randomized run
// checked against a pending-set / rotating-pointer reference model.
module tb_uart_tx_arbiter;
    localparam int unsigned NB = 8, NR = 4, NG = 2, NC = 9, FT = 176, GT = 16;

    logic clock = 1'b0;
    logic reset;
    logic s_ticks;

    uart_tx_arbiter_if #(.N_BITS_DATA(NB), .N_REQ(NR), .N_GRANT_BITS(NG)) bus ();

    uart_tx_arbiter #(
        .N_BITS_DATA(NB), .N_REQ(NR), .N_GRANT_BITS(NG),
        .N_CNT_BITS(NC), .FRAME_TICKS(FT), .GUARD_TICKS(GT)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .s_ticks(s_ticks),
        .bus    (bus.master)
    );

    always #5 clock = ~clock;

    int vectors = 0;
    int miscompares = 0;
    int tick_period = 0;
    int ticks_total = 0;
    int m_last = NR - 1;
    logic [NB-1:0] rdata [NR];

    // Baud tick source: one-clock strobe every tick_period clocks, 0 = stalled.
    initial begin
        int phase;
        phase = 0;
        s_ticks = 1'b0;
        forever begin
            @(negedge clock);
            if (tick_period <= 0) begin
                s_ticks = 1'b0;
                phase = 0;
            end else if (phase >= tick_period - 1) begin
                s_ticks = 1'b1;
                phase = 0;
            end else begin
                s_ticks = 1'b0;
                phase++;
            end
        end
    end

    always @(posedge clock) if (s_ticks === 1'b1) ticks_total <= ticks_total + 1;

    function automatic int model_winner(input logic [NR-1:0] v, input int last);
        for (int k = 1; k <= int'(NR); k++)
            if (v[(last + k) % NR]) return (last + k) % NR;
        return -1;
    endfunction

    task automatic put_data(input int i, input logic [NB-1:0] v);
        rdata[i] = v;
        bus.req_data[i*NB +: NB] = v;
    endtask

    task automatic wait_start(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (bus.tx_start === 1'b1) begin seen = 1'b1; return; end
        end
    endtask

    task automatic wait_idle(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (bus.busy === 1'b0) begin seen = 1'b1; return; end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick_period = 0;
        for (int i = 0; i < int'(NR); i++) put_data(i, 8'h00);
        bus.req_valid = 4'b1111;
        repeat (3) @(negedge clock);
        vectors++;
        if ({bus.busy, bus.tx_start, bus.req_ack} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: busy/start/ack=%b, required 000000", {bus.busy, bus.tx_start, bus.req_ack});
        end
        vectors++;
        if (bus.tx_data !== 8'h00 || bus.grant_id !== 2'd0) begin
            miscompares++;
            $display("FAIL reset_data: tx_data=%h grant_id=%0d, required 00/0", bus.tx_data, bus.grant_id);
        end
        bus.req_valid = 4'b0000;
        reset = 1'b1;
        m_last = NR - 1;
        repeat (2) @(negedge clock);
        vectors++;
        if (bus.busy !== 1'b0 || bus.tx_start !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_no_req: busy=%b tx_start=%b, required 0/0", bus.busy, bus.tx_start);
        end
    endtask

    task automatic test_single();
        bit ok;
        int t0;
        tick_period = 2;
        put_data(0, 8'hA5);
        bus.req_valid = 4'b0001;
        @(negedge clock);
        vectors++;
        if (bus.tx_start !== 1'b1 || bus.req_ack !== 4'b0001) begin
            miscompares++;
            $display("FAIL single_latency: tx_start=%b ack=%b, required 1/0001", bus.tx_start, bus.req_ack);
        end
        vectors++;
        if (bus.tx_data !== 8'hA5 || bus.grant_id !== 2'd0 || bus.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL single_payload: data=%h grant=%0d busy=%b, required a5/0/1", bus.tx_data, bus.grant_id, bus.busy);
        end
        m_last = 0;
        bus.req_valid = 4'b0000;
        @(negedge clock);
        vectors++;
        if (bus.tx_start !== 1'b0 || bus.req_ack !== 4'b0000) begin
            miscompares++;
            $display("FAIL single_pulse: tx_start=%b ack=%b, required 0/0000", bus.tx_start, bus.req_ack);
        end
        t0 = ticks_total;
        wait_idle(2000, ok);
        vectors++;
        if (!ok || (ticks_total - t0) != int'(FT + GT)) begin
            miscompares++;
            $display("FAIL single_duration: idle=%b ticks=%0d, required 1/%0d", ok, ticks_total - t0, FT + GT);
        end
        vectors++;
        if (bus.tx_data !== 8'hA5) begin
            miscompares++;
            $display("FAIL single_hold: tx_data=%h, required a5", bus.tx_data);
        end
    endtask

    task automatic test_round_robin();
        bit ok;
        int exp;
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        m_last = NR - 1;
        tick_period = 1;
        for (int i = 0; i < int'(NR); i++) put_data(i, 8'(8'h10 + i));
        bus.req_valid = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            exp = n % NR;
            wait_start(600, ok);
            vectors++;
            if (!ok || bus.grant_id !== 2'(exp) || bus.req_ack !== 4'(1 << exp) || bus.tx_data !== 8'(8'h10 + exp)) begin
                miscompares++;
                $display("FAIL rr_grant%0d: seen=%b grant=%0d ack=%b data=%h, required grant %0d data %h",
                         n, ok, bus.grant_id, bus.req_ack, bus.tx_data, exp, 8'(8'h10 + exp));
            end
            m_last = exp;
            @(negedge clock);
            vectors++;
            if (bus.req_ack !== 4'b0000 || bus.tx_start !== 1'b0) begin
                miscompares++;
                $display("FAIL rr_pulse%0d: ack=%b tx_start=%b, required 0000/0", n, bus.req_ack, bus.tx_start);
            end
        end
        bus.req_valid = 4'b0000;
        wait_idle(600, ok);
    endtask

    task automatic test_fairness();
        bit ok;
        int exp_seq [6] = '{2, 0, 2, 2, 2, 2};
        tick_period = 1;
        bus.req_valid = 4'b0100;
        for (int g = 0; g < 6; g++) begin
            if (g == 1) bus.req_valid = 4'b0101;
            wait_start(600, ok);
            vectors++;
            if (!ok || bus.grant_id !== 2'(exp_seq[g]) || bus.req_ack !== 4'(1 << exp_seq[g])) begin
                miscompares++;
                $display("FAIL fair_grant%0d: seen=%b grant=%0d ack=%b, required %0d", g, ok, bus.grant_id, bus.req_ack, exp_seq[g]);
            end
            bus.req_valid[exp_seq[g]] = 1'b0;
            m_last = exp_seq[g];
            @(negedge clock);
            if (g >= 2) bus.req_valid[2] = 1'b1;
        end
        bus.req_valid = 4'b0000;
        wait_idle(600, ok);
    endtask

    task automatic test_ticks();
        bit ok;
        int t0, t1, stall_bad, exp;
        tick_period = 3;
        put_data(1, 8'h3C);
        put_data(3, 8'hC3);
        bus.req_valid = 4'b0010;
        exp = model_winner(4'b0010, m_last);
        @(negedge clock);
        vectors++;
        if (bus.tx_start !== 1'b1 || bus.grant_id !== 2'(exp)) begin
            miscompares++;
            $display("FAIL tick_first: tx_start=%b grant=%0d, required 1/%0d", bus.tx_start, bus.grant_id, exp);
        end
        m_last = exp;
        bus.req_valid = 4'b0000;
        @(negedge clock);
        t0 = ticks_total;
        bus.req_valid = 4'b1000;
        wait_start(2000, ok);
        t1 = ticks_total - t0;
        vectors++;
        if (!ok || t1 < int'(FT + GT) || t1 > int'(FT + GT + 1) || bus.grant_id !== 2'd3) begin
            miscompares++;
            $display("FAIL tick_spacing: seen=%b ticks=%0d grant=%0d, required %0d..%0d grant 3", ok, t1, bus.grant_id, FT + GT, FT + GT + 1);
        end
        m_last = 3;
        bus.req_valid = 4'b0000;
        @(negedge clock);
        t0 = ticks_total;
        repeat (30) @(negedge clock);
        tick_period = 0;
        stall_bad = 0;
        repeat (500) begin
            @(negedge clock);
            if (bus.busy !== 1'b1 || bus.tx_start !== 1'b0) stall_bad++;
        end
        vectors++;
        if (stall_bad != 0) begin
            miscompares++;
            $display("FAIL tick_stall: %0d cycles not busy, required 0", stall_bad);
        end
        tick_period = 1;
        wait_idle(600, ok);
        vectors++;
        if (!ok || (ticks_total - t0) != int'(FT + GT)) begin
            miscompares++;
            $display("FAIL tick_resume: idle=%b ticks=%0d, required 1/%0d", ok, ticks_total - t0, FT + GT);
        end
    endtask

    task automatic test_withdraw_late();
        bit ok;
        int t0, bad, exp;
        tick_period = 1;
        put_data(0, 8'h5A);
        put_data(1, 8'h77);
        put_data(3, 8'h99);
        bus.req_valid = 4'b0001;
        exp = model_winner(4'b0001, m_last);
        @(negedge clock);
        vectors++;
        if (bus.tx_start !== 1'b1 || bus.grant_id !== 2'(exp)) begin
            miscompares++;
            $display("FAIL wd_first: tx_start=%b grant=%0d, required 1/%0d", bus.tx_start, bus.grant_id, exp);
        end
        m_last = exp;
        bus.req_valid = 4'b0000;
        @(negedge clock);
        t0 = ticks_total;
        bad = 0;
        repeat (20) begin @(negedge clock); if (bus.req_ack !== 4'b0 || bus.tx_start !== 1'b0) bad++; end
        bus.req_valid[1] = 1'b1;
        repeat (80) begin @(negedge clock); if (bus.req_ack !== 4'b0 || bus.tx_start !== 1'b0) bad++; end
        bus.req_valid[1] = 1'b0;
        for (int i = 0; i < 1000 && (ticks_total - t0) < 180; i++) begin
            @(negedge clock);
            if (bus.req_ack !== 4'b0 || bus.tx_start !== 1'b0) bad++;
        end
        bus.req_valid[3] = 1'b1;
        for (int i = 0; i < 200 && bus.busy !== 1'b0; i++) begin
            @(negedge clock);
            if (bus.req_ack !== 4'b0 || bus.tx_start !== 1'b0) bad++;
        end
        vectors++;
        if (bus.busy !== 1'b0 || bad != 0) begin
            miscompares++;
            $display("FAIL wd_quiet: busy=%b stray ack/start cycles=%0d, required 0/0", bus.busy, bad);
        end
        exp = model_winner(4'b1000, m_last);
        @(negedge clock);
        vectors++;
        if (bus.tx_start !== 1'b1 || bus.grant_id !== 2'(exp) || bus.req_ack !== 4'(1 << exp) || bus.tx_data !== 8'h99) begin
            miscompares++;
            $display("FAIL wd_late: tx_start=%b grant=%0d ack=%b data=%h, required 1/%0d data 99",
                     bus.tx_start, bus.grant_id, bus.req_ack, bus.tx_data, exp);
        end
        m_last = exp;
        bus.req_valid = 4'b0000;
        wait_idle(600, ok);
    endtask

    task automatic test_reset_mid();
        bit ok;
        int t0, exp;
        tick_period = 1;
        put_data(2, 8'($urandom()) | 8'h01);
        put_data(0, 8'h21);
        put_data(1, 8'h42);
        bus.req_valid = 4'b0100;
        exp = model_winner(4'b0100, m_last);
        @(negedge clock);
        m_last = exp;
        bus.req_valid = 4'b0000;
        @(negedge clock);
        t0 = ticks_total;
        for (int i = 0; i < 200 && (ticks_total - t0) < 50; i++) @(negedge clock);
        reset = 1'b0;
        #1;
        vectors++;
        if ({bus.busy, bus.tx_start, bus.req_ack, bus.tx_data, bus.grant_id} !== 16'b0) begin
            miscompares++;
            $display("FAIL rstmid_clear: busy=%b start=%b ack=%b data=%h grant=%0d, required all 0",
                     bus.busy, bus.tx_start, bus.req_ack, bus.tx_data, bus.grant_id);
        end
        @(negedge clock);
        reset = 1'b1;
        m_last = NR - 1;
        bus.req_valid = 4'b0011;
        exp = model_winner(4'b0011, m_last);
        @(negedge clock);
        vectors++;
        if (bus.tx_start !== 1'b1 || bus.grant_id !== 2'(exp) || bus.req_ack !== 4'(1 << exp) || bus.tx_data !== 8'h21) begin
            miscompares++;
            $display("FAIL rstmid_restart: start=%b grant=%0d ack=%b data=%h, required 1/%0d data 21",
                     bus.tx_start, bus.grant_id, bus.req_ack, bus.tx_data, exp);
        end
        m_last = exp;
        bus.req_valid[exp] = 1'b0;
        exp = model_winner(4'b0010, m_last);
        wait_start(600, ok);
        vectors++;
        if (!ok || bus.grant_id !== 2'(exp) || bus.tx_data !== 8'h42) begin
            miscompares++;
            $display("FAIL rstmid_next: seen=%b grant=%0d data=%h, required %0d data 42", ok, bus.grant_id, bus.tx_data, exp);
        end
        m_last = exp;
        bus.req_valid = 4'b0000;
        wait_idle(600, ok);
    endtask

    task automatic test_random();
        bit ok;
        int t0, exp, r;
        logic [NR-1:0] pend, newbits;
        logic [NB-1:0] saved;
        pend = '0;
        for (int it = 0; it < 40; it++) begin
            tick_period = $urandom_range(1, 3);
            newbits = 4'($urandom());
            if ((pend | newbits) == '0) newbits = 4'(1 << $urandom_range(0, NR - 1));
            for (int i = 0; i < int'(NR); i++)
                if (newbits[i] && !pend[i]) put_data(i, 8'($urandom()));
            pend = pend | newbits;
            bus.req_valid = pend;
            exp = model_winner(pend, m_last);
            @(negedge clock);
            vectors++;
            if (bus.tx_start !== 1'b1 || bus.grant_id !== 2'(exp) || bus.req_ack !== 4'(1 << exp) || bus.tx_data !== rdata[exp]) begin
                miscompares++;
                $display("FAIL rand_grant%0d: start=%b grant=%0d ack=%b data=%h, required 1/%0d data %h",
                         it, bus.tx_start, bus.grant_id, bus.req_ack, bus.tx_data, exp, rdata[exp]);
            end
            saved = rdata[exp];
            m_last = exp;
            pend[exp] = 1'b0;
            bus.req_valid = pend;
            put_data(exp, ~saved);
            @(negedge clock);
            vectors++;
            if (bus.req_ack !== 4'b0 || bus.tx_start !== 1'b0 || bus.tx_data !== saved) begin
                miscompares++;
                $display("FAIL rand_after%0d: ack=%b start=%b data=%h, required 0000/0 data %h",
                         it, bus.req_ack, bus.tx_start, bus.tx_data, saved);
            end
            t0 = ticks_total;
            repeat ($urandom_range(0, 50)) @(negedge clock);
            if ($urandom_range(0, 3) == 0) begin
                r = $urandom_range(0, NR - 1);
                pend[r] = 1'b0;
            end
            if ($urandom_range(0, 2) == 0) begin
                r = $urandom_range(0, NR - 1);
                if (!pend[r]) put_data(r, 8'($urandom()));
                pend[r] = 1'b1;
            end
            bus.req_valid = pend;
            wait_idle(2000, ok);
            vectors++;
            if (!ok || (ticks_total - t0) != int'(FT + GT) || bus.tx_data !== saved) begin
                miscompares++;
                $display("FAIL rand_frame%0d: idle=%b ticks=%0d data=%h, required 1/%0d data %h",
                         it, ok, ticks_total - t0, bus.tx_data, FT + GT, saved);
            end
        end
        bus.req_valid = '0;
        repeat (3) @(negedge clock);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0;
        bus.req_valid = '0;
        bus.req_data = '0;
        repeat (2) @(negedge clock);
        test_reset();
        test_single();
        test_round_robin();
        test_fairness();
        test_ticks();
        test_withdraw_late();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
